// File: rtl/fp_fir_pkg.sv
// Shared definitions for the time-multiplexed FP FIR: FSM state codes, the +0.0
// pattern and the default tap count.
package fp_fir_pkg;

    localparam int TAP_CNT_DEF = 31;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

endpackage

// File: rtl/fp_fir_mac_sequencer_if.sv
// Sample-in, MAC-issue, result-capture and filtered-out signals of the FIR sequencer.
// master = the sequencer itself, slave = its environment (source, MAC, sink).
interface fp_fir_mac_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(fp_fir_pkg::TAP_CNT_DEF)
);
    logic              valid_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_in;
    logic              mac_valid;
    logic              mac_ready;
    logic [DATA_W-1:0] mac_sample;
    logic [ADDR_W-1:0] coef_addr;
    logic              mac_first;
    logic              mac_last;
    logic              acc_valid;
    logic [DATA_W-1:0] acc_result;
    logic              valid_out;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              proto_err;

    modport master (
        input  valid_in, data_in, mac_ready, acc_valid, acc_result, out_ready,
        output ready_in, mac_valid, mac_sample, coef_addr, mac_first, mac_last,
               valid_out, data_out, busy, proto_err
    );

    modport slave (
        output valid_in, data_in, mac_ready, acc_valid, acc_result, out_ready,
        input  ready_in, mac_valid, mac_sample, coef_addr, mac_first, mac_last,
               valid_out, data_out, busy, proto_err
    );
endinterface

// File: rtl/fp_fir_delay_line.sv
// Circular sample store: one write port, combinational read by index, all entries
// cleared to +0.0 on reset. Pointer arithmetic is owned by the caller.
module fp_fir_delay_line
    import fp_fir_pkg::*;
#(
    parameter int DEPTH  = TAP_CNT_DEF,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                mem[i] <= DATA_W'(FP_ZERO);
            else if (wr_en && wr_addr == ADDR_W'(i))
                mem[i] <= wr_data;
        end
    end

    // Indices past DEPTH only exist when DEPTH is not a power of two; read them as +0.0.
    assign rd_data = ({1'b0, rd_addr} < DEPTH_X) ? mem[rd_addr] : DATA_W'(FP_ZERO);

endmodule

// File: rtl/fp_fir_mac_sequencer.sv
// Time-multiplexed FIR controller: buffers one sample, walks TAP_CNT (sample, coef)
// operations through a shared external FP MAC, then presents the accumulated result.
module fp_fir_mac_sequencer
    import fp_fir_pkg::*;
#(
    parameter int TAP_CNT = TAP_CNT_DEF,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_fir_mac_sequencer_if.master bus
);
    localparam int ADDR_W = $clog2(TAP_CNT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAP_CNT - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] tap;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ready;
    logic              accept;
    logic              fire;
    logic              last_fire;
    logic              capture;

    assign ready     = (state == ST_IDLE) && !rst;
    assign accept    = ready && bus.valid_in;
    assign fire      = (state == ST_ISSUE) && bus.mac_ready;
    assign last_fire = fire && (tap == LAST_IDX);
    // A result arriving with the final handshake is as good as one arriving in WAIT.
    assign capture   = bus.acc_valid && ((state == ST_WAIT) || last_fire);

    fp_fir_delay_line #(
        .DEPTH  (TAP_CNT),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dline (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tap     <= '0;
            valid_q <= 1'b0;
            data_q  <= DATA_W'(FP_ZERO);
            perr_q  <= 1'b0;
        end else begin
            if (bus.acc_valid && !capture)
                perr_q <= 1'b1;
            if (capture) begin
                data_q  <= bus.acc_result;
                valid_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rd_ptr <= wr_ptr;
                        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                        tap    <= '0;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fire) begin
                        // Walk backwards in time: tap k reads x[n-k].
                        rd_ptr <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - 1'b1;
                        if (tap == LAST_IDX) begin
                            tap   <= '0;
                            state <= bus.acc_valid ? ST_OUT : ST_WAIT;
                        end else begin
                            tap <= tap + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.acc_valid)
                        state <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_in   = ready;
    assign bus.mac_valid  = (state == ST_ISSUE);
    assign bus.mac_sample = rd_data;
    assign bus.coef_addr  = tap;
    assign bus.mac_first  = (state == ST_ISSUE) && (tap == '0);
    assign bus.mac_last   = (state == ST_ISSUE) && (tap == LAST_IDX);
    assign bus.valid_out  = valid_q;
    assign bus.data_out   = data_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.proto_err  = perr_q;

endmodule

// File: tb/tb_fp_fir_mac_sequencer.sv
// Bench for fp_fir_mac_sequencer: transaction-level history model checked every cycle,
// a small MAC responder, and directed scenarios with literal expectations.
module tb_fp_fir_mac_sequencer;
    localparam int TAPS = 31;
    localparam int DW   = 32;
    localparam int AW   = $clog2(TAPS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_fir_mac_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) ifc();

    fp_fir_mac_sequencer #(.TAP_CNT(TAPS), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // MAC responder: acc_valid pulses acc_lat cycles after the last handshake.
    bit          auto_mac = 1'b1;
    int          acc_lat  = 3;
    int          cd       = 0;
    logic [31:0] res_val  = 32'h0;
    logic        mac_acc_v = 1'b0, man_acc_v = 1'b0;
    logic [31:0] mac_acc_r = 32'h0, man_acc_r = 32'h0;
    bit          bp_mode = 1'b0;
    int          bp_k = 0;
    logic [3:0]  bp_pat = 4'b1001;

    assign ifc.acc_valid  = auto_mac ? mac_acc_v : man_acc_v;
    assign ifc.acc_result = auto_mac ? mac_acc_r : man_acc_r;

    initial begin
        ifc.mac_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) cd = 0;
            mac_acc_v = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mac_acc_v = 1'b1;
                    mac_acc_r = res_val;
                end
            end
            ifc.mac_ready = bp_mode ? bp_pat[bp_k % 4] : 1'b1;
            bp_k++;
        end
    end

    // Model: every accepted sample is appended to hist; tap k of sample n reads x[n-k],
    // which is +0.0 for anything before the last reset.
    int          ph = 0;  // 0 idle, 1 issuing, 2 awaiting result, 3 presenting result
    int          m_tap = 0, m_n = 0;
    logic [31:0] hist[$];
    logic [31:0] m_data = 32'h0;
    bit          m_perr = 1'b0;

    logic [31:0] seen[0:31];
    int hs_cnt, first_cnt, last_cnt, stall_cnt;

    function automatic logic [31:0] exp_sample(input int idx);
        return (idx < 0) ? 32'h0 : hist[idx];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_mac_valid", 32'(ifc.mac_valid), 32'h0);
            check("rst_busy",      32'(ifc.busy),      32'h0);
            check("rst_valid_out", 32'(ifc.valid_out), 32'h0);
            check("rst_data_out",  ifc.data_out,       32'h0);
            check("rst_proto_err", 32'(ifc.proto_err), 32'h0);
            ph = 0; m_tap = 0; m_data = 32'h0; m_perr = 1'b0;
            hist.delete();
            if (auto_mac) cd = 0;
        end else begin
            check("ready_in",  32'(ifc.ready_in),  32'(ph == 0));
            check("busy",      32'(ifc.busy),      32'(ph != 0));
            check("mac_valid", 32'(ifc.mac_valid), 32'(ph == 1));
            check("valid_out", 32'(ifc.valid_out), 32'(ph == 3));
            check("data_out",  ifc.data_out,       m_data);
            check("proto_err", 32'(ifc.proto_err), 32'(m_perr));
            if (ph == 1) begin
                check("mac_sample", ifc.mac_sample,      exp_sample(m_n - m_tap));
                check("coef_addr",  32'(ifc.coef_addr),  m_tap);
                check("mac_first",  32'(ifc.mac_first),  32'(m_tap == 0));
                check("mac_last",   32'(ifc.mac_last),   32'(m_tap == TAPS - 1));
            end
            if (ifc.mac_valid && ifc.mac_ready) begin
                seen[ifc.coef_addr] = ifc.mac_sample;
                hs_cnt++;
                if (ifc.mac_first) first_cnt++;
                if (ifc.mac_last)  last_cnt++;
                if (auto_mac && ifc.mac_last) cd = acc_lat;
            end
            if (ifc.mac_valid && !ifc.mac_ready) stall_cnt++;
            case (ph)
                0: begin
                    if (ifc.acc_valid) m_perr = 1'b1;
                    if (ifc.valid_in) begin
                        hist.push_back(ifc.data_in);
                        m_n = hist.size() - 1; m_tap = 0; ph = 1;
                    end
                end
                1: begin
                    if (ifc.mac_ready && m_tap == TAPS - 1) begin
                        if (ifc.acc_valid) begin m_data = ifc.acc_result; ph = 3; end
                        else ph = 2;
                    end else begin
                        if (ifc.acc_valid) m_perr = 1'b1;
                        if (ifc.mac_ready) m_tap++;
                    end
                end
                2: if (ifc.acc_valid) begin m_data = ifc.acc_result; ph = 3; end
                default: begin
                    if (ifc.acc_valid) m_perr = 1'b1;
                    if (ifc.out_ready) ph = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        for (int k = 0; k < 32; k++) seen[k] = 32'hFFFF_FFFF;
        hs_cnt = 0; first_cnt = 0; last_cnt = 0; stall_cnt = 0;
    endtask

    task automatic send(input logic [31:0] d);
        int t = 0;
        ifc.valid_in = 1'b1;
        ifc.data_in  = d;
        while (!ifc.ready_in && t < 200) begin step(); t++; end
        if (t >= 200) check("send_timeout", 32'h1, 32'h0);
        step();
        ifc.valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (ifc.busy && t < 300) begin step(); t++; end
        if (t >= 300) check("idle_timeout", 32'h1, 32'h0);
    endtask

    int bad;

    initial begin
        ifc.valid_in = 1'b0; ifc.data_in = 32'h0; ifc.out_ready = 1'b1;
        rst = 1'b0;
        clear_log();
        #1 rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("post_reset_ready", 32'(ifc.ready_in), 32'h1);
        check("post_reset_busy",  32'(ifc.busy),     32'h0);

        // Impulse: 1.0 then zeros; the 1.0 walks to coef_addr = s on sample s.
        for (int s = 0; s < TAPS; s++) begin
            clear_log();
            res_val = 32'hA000_0000 + 32'(s);
            send((s == 0) ? 32'h3F80_0000 : 32'h0);
            wait_idle();
            bad = 0;
            for (int k = 0; k < TAPS; k++)
                if (seen[k] !== ((k == s) ? 32'h3F80_0000 : 32'h0)) bad++;
            check("impulse_position", bad, 0);
            check("impulse_handshakes", hs_cnt, TAPS);
            check("impulse_result", ifc.data_out, 32'hA000_0000 + 32'(s));
        end

        // Backpressure with mac_ready 1,0,0,1.
        clear_log();
        bp_mode = 1'b1; bp_k = 0;
        send(32'h1111_1111);
        wait_idle();
        bp_mode = 1'b0;
        check("bp_handshakes", hs_cnt, TAPS);
        check("bp_first_cnt",  first_cnt, 1);
        check("bp_last_cnt",   last_cnt, 1);
        check("bp_stalled",    32'(stall_cnt > 0), 32'h1);
        check("bp_tap0",       seen[0], 32'h1111_1111);

        // Output stall for 5 cycles.
        out_stall: begin
            int t = 0;
            ifc.out_ready = 1'b0;
            res_val = 32'h4049_0FDB;
            send(32'h2222_2222);
            while (!ifc.valid_out && t < 200) begin step(); t++; end
            if (t >= 200) check("ostall_timeout", 32'h1, 32'h0);
            for (int c = 0; c < 5; c++) begin
                check("ostall_valid", 32'(ifc.valid_out), 32'h1);
                check("ostall_data",  ifc.data_out, 32'h4049_0FDB);
                check("ostall_ready_in", 32'(ifc.ready_in), 32'h0);
                step();
            end
            ifc.out_ready = 1'b1;
            check("ostall_hs_ready_in", 32'(ifc.ready_in), 32'h0);
            step();
            check("ostall_after_ready_in", 32'(ifc.ready_in), 32'h1);
            check("ostall_after_valid",    32'(ifc.valid_out), 32'h0);
        end

        // Result arriving together with the last handshake goes straight to output.
        auto_mac = 1'b0;
        send(32'h3333_3333);
        repeat (TAPS - 1) step();
        check("coinc_last", 32'(ifc.mac_last), 32'h1);
        man_acc_v = 1'b1; man_acc_r = 32'h1234_5678;
        step();
        man_acc_v = 1'b0;
        check("coinc_valid_out", 32'(ifc.valid_out), 32'h1);
        check("coinc_data_out",  ifc.data_out, 32'h1234_5678);
        check("coinc_no_err",    32'(ifc.proto_err), 32'h0);
        step();
        check("coinc_idle", 32'(ifc.busy), 32'h0);

        // Spurious result in IDLE.
        man_acc_v = 1'b1; man_acc_r = 32'hDEAD_BEEF;
        step();
        man_acc_v = 1'b0;
        check("spur_err",  32'(ifc.proto_err), 32'h1);
        check("spur_data", ifc.data_out, 32'h1234_5678);
        step();
        check("spur_sticky", 32'(ifc.proto_err), 32'h1);
        auto_mac = 1'b1;
        send(32'h4444_4444);
        wait_idle();
        check("spur_sticky_op", 32'(ifc.proto_err), 32'h1);

        // Reset in the middle of issuing, at tap 12.
        send(32'h5555_5555);
        repeat (12) step();
        check("rmid_tap", 32'(ifc.coef_addr), 32'd12);
        rst = 1'b1;
        #1;
        check("rmid_mac_valid", 32'(ifc.mac_valid), 32'h0);
        check("rmid_busy",      32'(ifc.busy),      32'h0);
        check("rmid_data_out",  ifc.data_out,       32'h0);
        check("rmid_proto_err", 32'(ifc.proto_err), 32'h0);
        step();
        rst = 1'b0;
        step();
        clear_log();
        send(32'h6666_6666);
        wait_idle();
        check("rmid_tap0", seen[0], 32'h6666_6666);
        bad = 0;
        for (int k = 1; k < TAPS; k++) if (seen[k] !== 32'h0) bad++;
        check("rmid_cleared", bad, 0);

        // Wrap: samples 1..40 through the 31-entry ring.
        for (int j = 1; j <= 40; j++) begin
            clear_log();
            send(32'(j));
            wait_idle();
            if (j == 33 || j == 40) begin
                bad = 0;
                for (int k = 0; k < TAPS; k++) if (seen[k] !== 32'(j - k)) bad++;
                check((j == 33) ? "wrap_s33" : "wrap_s40", bad, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
